// File: rtl/tdm_demux_1x4_pkg.sv
// Shared constants for the 1-to-4 TDM demultiplexer.
//   NUM_CH   : number of TDM slots (channels) per frame
//   SLOT_W   : width of the slot counter
//   ST_HUNT  : waiting for a frame marker (reset state)
//   ST_LOCK  : frame alignment established, slots are being routed
package tdm_demux_1x4_pkg;

    localparam int NUM_CH  = 4;
    localparam int SLOT_W  = 2;
    localparam int STATE_W = 1;

    localparam logic [STATE_W-1:0] ST_HUNT = 1'b0;
    localparam logic [STATE_W-1:0] ST_LOCK = 1'b1;

endpackage

// File: rtl/tdm_demux_1x4_chan.sv
// chan_sipo: serial-in / parallel-out word collector for one TDM channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : discard the partial word
//   shift_i    : shift bit_i in at the LSB end (earliest bit ends up at the MSB)
//   bit_i      : serial data bit
//   word_o     : current WIDTH-bit word contents
module chan_sipo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (clr_i) begin
            // Clear and shift together: the current bit starts a fresh word.
            word_q <= shift_i ? {{(WIDTH-1){1'b0}}, bit_i} : '0;
        end else if (shift_i) begin
            word_q <= {word_q[WIDTH-2:0], bit_i};
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: splits a 4-slot serial TDM stream into four channels.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : slot strobe; din/sync sampled only when high
//   din, sync  : serial data and frame marker (high with the slot-0 bit)
//   y0..y3     : last bit received on each channel (registered)
//   data_out   : four assembled WIDTH-bit words, channel k at [k*WIDTH +: WIDTH]
//   valid      : one-cycle pulse when data_out is reloaded
//   locked     : high while frame alignment is held
//   sync_err   : one-cycle pulse on a framing violation
module tdm_demux_1x4
    import tdm_demux_1x4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                din,
    input  logic                sync,
    output logic                y0,
    output logic                y1,
    output logic                y2,
    output logic                y3,
    output logic [4*WIDTH-1:0]  data_out,
    output logic                valid,
    output logic                locked,
    output logic                sync_err
);

    localparam int FW = $clog2(WIDTH);
    localparam logic [FW-1:0] FRAME_LAST = FW'(WIDTH - 1);

    logic [STATE_W-1:0]  state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic [NUM_CH-1:0]   shift;
    logic [NUM_CH-1:0]   y_q;
    logic                clr;
    logic                load;
    logic                err;
    logic [WIDTH-1:0]    word [NUM_CH];
    logic [4*WIDTH-1:0]  data_q;
    logic                valid_q;
    logic                err_q;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        frame_d = frame_q;
        shift   = '0;
        clr     = 1'b0;
        load    = 1'b0;
        err     = 1'b0;
        if (en) begin
            if (state_q == ST_HUNT) begin
                if (sync) begin
                    state_d  = ST_LOCK;
                    slot_d   = 2'd1;
                    frame_d  = '0;
                    clr      = 1'b1;
                    shift[0] = 1'b1;
                end
            end else begin
                if (sync && slot_q != 2'd0) begin
                    // Early marker: realign on this bit without leaving LOCK.
                    err      = 1'b1;
                    clr      = 1'b1;
                    shift[0] = 1'b1;
                    slot_d   = 2'd1;
                    frame_d  = '0;
                end else if (!sync && slot_q == 2'd0) begin
                    // Missing marker: alignment lost, this bit is dropped.
                    err     = 1'b1;
                    clr     = 1'b1;
                    state_d = ST_HUNT;
                    slot_d  = 2'd0;
                    frame_d = '0;
                end else begin
                    shift[slot_q] = 1'b1;
                    slot_d        = slot_q + 2'd1;
                    if (slot_q == 2'd3) begin
                        if (frame_q == FRAME_LAST) begin
                            frame_d = '0;
                            load    = 1'b1;
                        end else begin
                            frame_d = frame_q + 1'b1;
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        chan_sipo #(.WIDTH(WIDTH)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (clr),
            .shift_i (shift[g]),
            .bit_i   (din),
            .word_o  (word[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
            slot_q  <= '0;
            frame_q <= '0;
            y_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            frame_q <= frame_d;
            valid_q <= load;
            err_q   <= err;
            // A channel's live bit follows exactly the cycles its word shifts.
            y_q     <= (y_q & ~shift) | ({NUM_CH{din}} & shift);
            if (load) begin
                // Channel 3's last bit is still on din; take it directly.
                data_q <= {word[3][WIDTH-2:0], din, word[2], word[1], word[0]};
            end
        end
    end

    assign y0       = y_q[0];
    assign y1       = y_q[1];
    assign y2       = y_q[2];
    assign y3       = y_q[3];
    assign data_out = data_q;
    assign valid    = valid_q;
    assign locked   = (state_q == ST_LOCK);
    assign sync_err = err_q;

endmodule

// File: doc/tdm_demux_1x4.md
TDM_DEMUX_1X4 -- requirements
Module: tdm_demux_1x4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bits collected per channel word (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: slot strobe; din/sync are sampled only when en=1.
REQ-005 The block SHALL have port din, input, 1 bit: serial TDM stream carrying one bit per slot, 4 slots per frame, slot k = channel k.
REQ-006 The block SHALL have port sync, input, 1 bit: frame marker, high with the slot-0 bit.
REQ-007 The block SHALL have ports y0, y1, y2, y3, output, 1 bit each: registered live demuxed bit per channel.
REQ-008 The block SHALL have port data_out, output, 4*WIDTH bits: assembled words, channel k at bits [k*WIDTH +: WIDTH].
REQ-009 The block SHALL have port valid, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-010 The block SHALL have port locked, output, 1 bit: high while in LOCK state.
REQ-011 The block SHALL have port sync_err, output, 1 bit: one-cycle pulse on framing violation.

Function
REQ-012 The FSM SHALL have exactly two states, HUNT (reset state) and LOCK.
REQ-013 In HUNT, an en=1 cycle with sync=0 SHALL be ignored, with no output change.
REQ-014 In HUNT, an en=1 cycle with sync=1 SHALL take din as slot 0 of frame 0, enter LOCK, and set the slot counter to 1.
REQ-015 In LOCK, each en=1 cycle SHALL route din to channel slot_cnt; slot_cnt SHALL be 2 bits and wrap 3->0.
REQ-016 In LOCK, sync=1 with slot_cnt!=0 SHALL pulse sync_err, clear the frame counter and all partial words, and treat the current bit as slot 0 of frame 0 (immediate relock, locked stays 1).
REQ-017 In LOCK, sync=0 with slot_cnt=0 SHALL pulse sync_err, discard that bit and partial words, and return to HUNT (locked falls next cycle).
REQ-018 y[k] SHALL update one cycle after channel k's bit is sampled and hold otherwise (latency 1).
REQ-019 Each channel SHALL shift bits in MSB first: the frame-0 bit is word bit WIDTH-1.
REQ-020 The frame counter SHALL increment after slot 3, range 0..WIDTH-1, and wrap to 0.
REQ-021 When the slot-3 bit of frame WIDTH-1 is sampled, data_out SHALL load all four complete words and valid SHALL pulse on the next cycle; data_out SHALL hold until the next load.
REQ-022 With en=0, counters, FSM and outputs SHALL hold, and valid and sync_err SHALL be 0.
REQ-023 valid and sync_err SHALL never be high in the same cycle, because an erroring bit never completes a word.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force HUNT, slot_cnt=0, frame counter=0, partial words=0, y0..y3=0, data_out=0, valid=0, locked=0 and sync_err=0.
REQ-025 Reset asserted mid-frame SHALL discard all partial data; after release the block SHALL require a fresh sync.

Structure
REQ-026 The shared package SHALL hold the FSM state encoding (HUNT=0, LOCK=1), the NUM_CH=4 constant, and the slot counter width 2.
REQ-027 The block SHALL instantiate one sub-module per channel, chan_sipo (a WIDTH-bit shift-in register with shift enable and clear), 4 instances in total; the FSM, slot counter and frame counter SHALL stay in the top module.

Verification
REQ-028 The bench SHALL cover: reset, en=1, sync=0 for 10 cycles -> locked=0, y*=0, valid never asserted.
REQ-029 The bench SHALL cover: WIDTH=8, clean frames sending ch0=0xA5, ch1=0x3C, ch2=0xFF, ch3=0x00 MSB first -> valid pulses once, 1 cycle after the 32nd bit, with data_out=0x00FF3CA5.
REQ-030 The bench SHALL cover: a single frame with din pattern 1,0,1,1 -> y0..y3 = 1,0,1,1, each appearing 1 cycle after its slot.
REQ-031 The bench SHALL cover: sync raised at slot 2 in frame 3 -> sync_err pulse, locked stays 1, and the next valid occurs only after 8 further full frames counted from that bit.
REQ-032 The bench SHALL cover: sync missing at a slot 0 -> sync_err pulse, locked=0 next cycle, and no valid until resync plus 8 frames.
REQ-033 The bench SHALL cover: en toggled 0/1 every cycle during a word -> same data_out as contiguous en, with valid delayed accordingly; and rst_n pulsed low mid-frame -> all outputs 0 asynchronously.
